// File: rtl/wb_mem_bridge_pkg.sv
// Shared types and default constants for the Wishbone-to-memory-bus bridge.
// State encoding plus the address window, error data and timeout defaults.
package wb_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ACK
  } state_e;

  localparam logic [31:0] DEF_ADDR_BASE      = 32'h3000_0000;
  localparam logic [31:0] DEF_ADDR_MASK      = 32'hFF00_0000;
  localparam logic [31:0] DEF_ERR_DATA       = 32'hDEAD_BEEF;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  // Downstream bus is word addressed; byte offset travels on the byte enables.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/wb_mem_bridge_tmo.sv
// Transaction timeout counter: counts cycles while run is high, clears otherwise.
// expired flags the last permitted cycle so the bridge completes on the next edge.
module wb_mem_bridge_tmo #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  localparam int unsigned   CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/wb_mem_bridge.sv
// Caravel Wishbone slave bridging classic WB cycles onto the req/gnt/rvalid memory bus.
// Optional response timeout enabled by defining WB_MEM_BRIDGE_TIMEOUT_EN.
module wb_mem_bridge
  import wb_mem_bridge_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = DEF_ADDR_BASE,
  parameter logic [31:0] ADDR_MASK      = DEF_ADDR_MASK,
  parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        err_o
);

  state_e state;
  logic   aborted;
  logic   in_window;
  logic   keep;
  logic   timeout;
  logic   rsp_valid;

  assign in_window = (wbs_adr_i & ADDR_MASK) == ADDR_BASE;
  // The master still wants the result only if it never dropped cyc.
  assign keep      = wbs_cyc_i && !aborted;

`ifdef WB_MEM_BRIDGE_TIMEOUT_EN
  logic tmo_run;
  logic drain;

  assign tmo_run = (state == REQ) || (state == WAIT);

  wb_mem_bridge_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .run    (tmo_run),
    .expired(timeout)
  );

  // A response that arrives after its transaction timed out belongs to nobody.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      drain <= 1'b0;
    end else if (drain && rvalid_i) begin
      drain <= 1'b0;
    end else if ((state == WAIT) && timeout && !rvalid_i) begin
      drain <= 1'b1;
    end
  end

  assign rsp_valid = rvalid_i && !drain;
`else
  logic unused_tmo_cfg;

  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign rsp_valid      = rvalid_i;
`endif

  // NOTE: registered state and outputs use non-blocking assignments so every
  // branch sees the values from before this edge.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      aborted   <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      req_o     <= 1'b0;
      we_o      <= 1'b0;
      be_o      <= '0;
      addr_o    <= '0;
      wdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            if (in_window) begin
              addr_o  <= word_addr(wbs_adr_i);
              wdata_o <= wbs_dat_i;
              be_o    <= wbs_sel_i;
              we_o    <= wbs_we_i;
              req_o   <= 1'b1;
              aborted <= 1'b0;
              state   <= REQ;
            end else begin
              wbs_dat_o <= ERR_DATA;
              wbs_ack_o <= 1'b1;
              err_o     <= 1'b1;
              state     <= ACK;
            end
          end
        end

        REQ: begin
          if (!wbs_cyc_i) aborted <= 1'b1;
          if (gnt_i) begin
            req_o <= 1'b0;
            state <= WAIT;
          end else if (timeout) begin
            req_o <= 1'b0;
            err_o <= 1'b1;
            if (keep) begin
              wbs_dat_o <= ERR_DATA;
              wbs_ack_o <= 1'b1;
              state     <= ACK;
            end else begin
              state <= IDLE;
            end
          end
        end

        WAIT: begin
          if (!wbs_cyc_i) aborted <= 1'b1;
          if (rsp_valid) begin
            if (err_i) err_o <= 1'b1;
            if (keep) begin
              wbs_dat_o <= err_i ? ERR_DATA : (we_o ? 32'h0 : rdata_i);
              wbs_ack_o <= 1'b1;
              state     <= ACK;
            end else begin
              state <= IDLE;
            end
          end else if (timeout) begin
            err_o <= 1'b1;
            if (keep) begin
              wbs_dat_o <= ERR_DATA;
              wbs_ack_o <= 1'b1;
              state     <= ACK;
            end else begin
              state <= IDLE;
            end
          end
        end

        ACK: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_bridge.sv
// Directed bench for wb_mem_bridge: drives WB cycles and a scripted downstream responder.
// Timeout cases are compiled in when WB_MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_wb_mem_bridge;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        req_o, gnt, we_o, rvalid, err_i, err_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o, rdata;

  int checks = 0;
  int errors = 0;

  // Results of the most recent run_txn.
  int          n_ack, n_gnt, n_req, lat;
  logic        stable;
  logic [31:0] ack_dat;

  wb_mem_bridge #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .req_o    (req_o),
    .gnt_i    (gnt),
    .we_o     (we_o),
    .be_o     (be_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .rvalid_i (rvalid),
    .rdata_i  (rdata),
    .err_i    (err_i),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; wdat = '0;
    gnt = 0; rvalid = 0; rdata = '0; err_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  // One WB transaction against a scripted slave. gnt_dly: extra cycles req_o
  // waits before gnt (0 = same cycle req_o rises). rv_dly: cycles after the
  // grant edge before rvalid (-1 = never). drop_at: cycle to drop cyc (-1 = never).
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rd, input logic e, input int drop_at);
    int req_seen, g_c, ack_c;
    logic rv_done;
    n_ack = 0; n_gnt = 0; n_req = 0; lat = 0; stable = 1; ack_dat = '0;
    req_seen = 0; g_c = -1; ack_c = -1; rv_done = 0;
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    for (int c = 1; c <= 40; c++) begin
      tick();
      gnt = 0; rvalid = 0; err_i = 0; rdata = '0;
      if (req_o) begin
        n_req++;
        req_seen++;
        if (g_c > 0) stable = 0;
        if (addr_o !== {a[31:2], 2'b00} || wdata_o !== d || be_o !== s || we_o !== w) stable = 0;
        if (req_seen == gnt_dly + 1) begin
          gnt = 1;
          n_gnt++;
          g_c = c;
        end
      end else if (req_seen > 0 && g_c < 0) begin
        stable = 0;
      end
      if (g_c > 0 && c > g_c && !rv_done && rv_dly >= 0 && (c - g_c - 1) == rv_dly) begin
        rvalid = 1; rdata = rd; err_i = e; rv_done = 1;
      end
      if (ack) begin
        n_ack++;
        ack_dat = rdat;
        lat = c + 1;
        ack_c = c;
        cyc = 0; stb = 0;
      end
      if (c == drop_at) begin
        cyc = 0; stb = 0;
      end
      if (ack_c > 0 && c >= ack_c + 2) break;
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1;
    do_reset();

    check("rst_ack", ack, 0);
    check("rst_dat", rdat, 0);
    check("rst_req", req_o, 0);
    check("rst_we", we_o, 0);
    check("rst_be", be_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_err", err_o, 0);

    // Minimum-latency read: ack in the 4th cycle of stb.
    run_txn(0, 32'h3000_0010, 32'h0, 4'hF, 0, 0, 32'h1234_5678, 0, -1);
    check("rd_acks", n_ack, 1);
    check("rd_dat", ack_dat, 32'h1234_5678);
    check("rd_lat", lat, 4);
    check("rd_stable", stable, 1);
    check("rd_err", err_o, 0);
    check("rd_dat_hold", rdat, 32'h1234_5678);

    // Partial write: byte enables and write data forwarded, write ack data is 0.
    run_txn(1, 32'h3000_0004, 32'hA5A5_A5A5, 4'b0011, 0, 0, 32'hFFFF_0000, 0, -1);
    check("wr_acks", n_ack, 1);
    check("wr_gnts", n_gnt, 1);
    check("wr_dat", ack_dat, 32'h0);
    check("wr_stable", stable, 1);
    check("wr_be", be_o, 4'b0011);
    check("wr_we", we_o, 1);
    check("wr_wdata", wdata_o, 32'hA5A5_A5A5);

    // Grant delayed 5 cycles, unaligned address word-aligned on the bus.
    run_txn(1, 32'h3000_0107, 32'h0BAD_F00D, 4'b1100, 5, 0, 32'h0, 0, -1);
    check("dly_stable", stable, 1);
    check("dly_gnts", n_gnt, 1);
    check("dly_req_cycles", n_req, 6);
    check("dly_acks", n_ack, 1);
    check("dly_lat", lat, 9);
    check("dly_addr", addr_o, 32'h3000_0104);

    // Out-of-window read: immediate error ack, no downstream request.
    run_txn(0, 32'h2000_0000, 32'h0, 4'hF, 0, 0, 32'h5555_5555, 0, -1);
    check("oow_reqs", n_req, 0);
    check("oow_acks", n_ack, 1);
    check("oow_dat", ack_dat, 32'hDEAD_BEEF);
    check("oow_lat", lat, 2);
    check("oow_err", err_o, 1);
    run_txn(0, 32'h3000_0040, 32'h0, 4'hF, 0, 0, 32'h0000_0042, 0, -1);
    check("oow_next_dat", ack_dat, 32'h0000_0042);
    check("oow_err_sticky", err_o, 1);

    // Downstream error response.
    do_reset();
    check("err_clr", err_o, 0);
    run_txn(0, 32'h3000_0008, 32'h0, 4'hF, 0, 1, 32'h7777_7777, 1, -1);
    check("erri_acks", n_ack, 1);
    check("erri_dat", ack_dat, 32'hDEAD_BEEF);
    check("erri_err", err_o, 1);

    // cyc dropped while waiting for the response: no ack, data untouched.
    do_reset();
    run_txn(0, 32'h3000_0030, 32'h0, 4'hF, 0, 3, 32'h1111_1111, 0, 3);
    check("abort_acks", n_ack, 0);
    check("abort_gnts", n_gnt, 1);
    check("abort_dat_hold", rdat, 32'h0);
    check("abort_err", err_o, 0);
    run_txn(0, 32'h3000_0034, 32'h0, 4'hF, 0, 0, 32'h2222_2222, 0, -1);
    check("post_abort_lat", lat, 4);
    check("post_abort_dat", ack_dat, 32'h2222_2222);

    // Reset in the middle of a request.
    cyc = 1; stb = 1; we = 1; adr = 32'h3000_0050; wdat = 32'hCAFE_0001; sel = 4'hF;
    tick();
    check("mid_req_up", req_o, 1);
    rst_n = 0;
    tick();
    check("mid_rst_req", req_o, 0);
    check("mid_rst_addr", addr_o, 0);
    check("mid_rst_ack", ack, 0);
    rst_n = 1;
    idle_inputs();
    tick();
    run_txn(0, 32'h3000_0058, 32'h0, 4'hF, 0, 0, 32'h3333_3333, 0, -1);
    check("post_rst_lat", lat, 4);
    check("post_rst_dat", ack_dat, 32'h3333_3333);

`ifdef WB_MEM_BRIDGE_TIMEOUT_EN
    // No response: forced completion after 8 cycles in REQ+WAIT.
    do_reset();
    run_txn(0, 32'h3000_0020, 32'h0, 4'hF, 0, -1, 32'h0, 0, -1);
    check("tmo_acks", n_ack, 1);
    check("tmo_dat", ack_dat, 32'hDEAD_BEEF);
    check("tmo_lat", lat, 10);
    check("tmo_err", err_o, 1);

    // The late response lands in the next transaction's wait and is swallowed.
    cyc = 1; stb = 1; we = 0; adr = 32'h3000_0024; sel = 4'hF;
    tick();
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; rdata = 32'hBAD0_BAD0;
    tick();
    check("drain_no_ack", ack, 0);
    rdata = 32'h600D_F00D;
    tick();
    check("drain_ack", ack, 1);
    check("drain_dat", rdat, 32'h600D_F00D);
    idle_inputs();
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
